// File: rtl/weight_tile_writer_pkg.sv
// ==== weight_tile_writer_pkg : shared constants, Info tag struct, FSM states ====
// ==== Rev 1.0                                                                 ====
`default_nettype none

package weight_tile_writer_pkg;

  localparam int SZI       = 16;
  localparam int SZJ       = 16;
  localparam int LANE_W    = 8;
  localparam int MAX_TILES = 4096;

  localparam int WORD_W    = SZJ * LANE_W;
  localparam int ROW_W     = $clog2(SZI);
  localparam int ROWS_W    = ROW_W + 1;
  localparam int TILE_W    = $clog2(MAX_TILES);
  localparam int NTILES_W  = TILE_W + 1;

  typedef struct packed {
    logic valid;
    logic new_tile_k;
    logic last_elm;
  } info_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Out-of-range row counts fall back to a full tile.
  function automatic logic [ROW_W-1:0] clamp_last_row(input logic [ROWS_W-1:0] rows);
    if (rows == '0 || rows > ROWS_W'(SZI)) return ROW_W'(SZI - 1);
    return ROW_W'(rows - 1'b1);
  endfunction

  function automatic logic needs_pad(input logic [ROWS_W-1:0] rows);
    return (rows != '0) && (rows < ROWS_W'(SZI));
  endfunction

  function automatic logic [TILE_W-1:0] clamp_last_tile(input logic [NTILES_W-1:0] n);
    if (n == '0) return '0;
    if (n > NTILES_W'(MAX_TILES)) return TILE_W'(MAX_TILES - 1);
    return TILE_W'(n - 1'b1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/weight_tile_writer_counter.sv
// ==== tile_row_counter : row/tile counters with wrap and terminal-count flags ====
// ==== Rev 1.0                                                                  ====
`default_nettype none

module tile_row_counter
  import weight_tile_writer_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              row_inc_i,
  input  logic [ROW_W-1:0]  last_data_row_i,
  input  logic [TILE_W-1:0] last_tile_i,
  output logic              is_first_row_o,
  output logic              is_last_data_row_o,
  output logic              is_last_row_o,
  output logic              is_last_tile_o
);

  logic [ROW_W-1:0]  row_q, row_d;
  logic [TILE_W-1:0] tile_q, tile_d;

  assign is_first_row_o     = (row_q == '0);
  assign is_last_data_row_o = (row_q == last_data_row_i);
  assign is_last_row_o      = (row_q == ROW_W'(SZI - 1));
  assign is_last_tile_o     = (tile_q == last_tile_i);

  // Row counter wraps naturally; the tile count advances on that wrap.
  always_comb begin
    row_d  = row_q;
    tile_d = tile_q;
    if (clear_i) begin
      row_d  = '0;
      tile_d = '0;
    end else if (row_inc_i) begin
      row_d = row_q + 1'b1;
      if (is_last_row_o && !is_last_tile_o) tile_d = tile_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_q  <= '0;
      tile_q <= '0;
    end else begin
      row_q  <= row_d;
      tile_q <= tile_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/weight_tile_writer.sv
// ==== weight_tile_writer : packs a word stream into zero-padded SZI-row FIFO tiles ====
// ==== Rev 1.0                                                                       ====
`default_nettype none

module weight_tile_writer
  import weight_tile_writer_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [ROWS_W-1:0]   tile_rows,
  input  logic [NTILES_W-1:0] num_tiles,
  input  logic                s_valid,
  input  logic [WORD_W-1:0]   s_value,
  output logic                s_ready,
  input  logic                fifo_half_full,
  output logic                wrreq,
  output logic [WORD_W-1:0]   wr_value,
  output logic                wr_valid,
  output logic                wr_new_tile_k,
  output logic                wr_last_elm,
  output logic                busy,
  output logic                done
);

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   last_row_q, last_row_d;
  logic [TILE_W-1:0]  last_tile_q, last_tile_d;
  logic               pad_q, pad_d;
  info_t              info_q, info_d;
  logic [WORD_W-1:0]  value_q, value_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic w_load, w_accept, w_issue;
  logic w_first_row, w_last_data_row, w_last_row, w_last_tile;

  tile_row_counter u_cnt (
    .clk                (clk),
    .resetn             (resetn),
    .clear_i            (w_load),
    .row_inc_i          (w_issue),
    .last_data_row_i    (last_row_q),
    .last_tile_i        (last_tile_q),
    .is_first_row_o     (w_first_row),
    .is_last_data_row_o (w_last_data_row),
    .is_last_row_o      (w_last_row),
    .is_last_tile_o     (w_last_tile)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Tile-end decision is folded into the last row's transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = STREAM;
      STREAM: if (w_accept && w_last_data_row)
                state_d = pad_q ? PAD : (w_last_tile ? DONE : STREAM);
      PAD:    if (w_issue && w_last_row)
                state_d = w_last_tile ? DONE : STREAM;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    w_load   = 1'b0;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    unique case (state_q)
      IDLE:   w_load = start;
      STREAM: begin
        s_ready  = !fifo_half_full;
        w_accept = s_valid && !fifo_half_full;
        w_issue  = w_accept;
      end
      PAD:    w_issue = !fifo_half_full;
      default: ;
    endcase
  end

  always_comb begin
    last_row_d        = w_load ? clamp_last_row(tile_rows)   : last_row_q;
    last_tile_d       = w_load ? clamp_last_tile(num_tiles)  : last_tile_q;
    pad_d             = w_load ? needs_pad(tile_rows)        : pad_q;
    info_d.valid      = w_issue;
    info_d.new_tile_k = w_issue && w_first_row;
    info_d.last_elm   = w_issue && w_last_row && w_last_tile;
    value_d           = w_accept ? s_value : '0;
    busy_d            = (state_d != IDLE) || (state_q == DONE);
    done_d            = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_row_q  <= '0;
      last_tile_q <= '0;
      pad_q       <= 1'b0;
      info_q      <= '0;
      value_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      last_row_q  <= last_row_d;
      last_tile_q <= last_tile_d;
      pad_q       <= pad_d;
      info_q      <= info_d;
      value_q     <= value_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wrreq         = info_q.valid;
  assign wr_valid      = info_q.valid;
  assign wr_new_tile_k = info_q.new_tile_k;
  assign wr_last_elm   = info_q.last_elm;
  assign wr_value      = value_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_weight_tile_writer.sv
// ==== tb_weight_tile_writer : directed table-driven bench for weight_tile_writer ====
// ==== Rev 1.0                                                                     ====
`default_nettype none

module tb_weight_tile_writer;
  import weight_tile_writer_pkg::*;

  logic                clk = 1'b0;
  logic                resetn;
  logic                start;
  logic [ROWS_W-1:0]   tile_rows;
  logic [NTILES_W-1:0] num_tiles;
  logic                s_valid;
  logic [WORD_W-1:0]   s_value;
  logic                s_ready;
  logic                fifo_half_full;
  logic                wrreq;
  logic [WORD_W-1:0]   wr_value;
  logic                wr_valid;
  logic                wr_new_tile_k;
  logic                wr_last_elm;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  weight_tile_writer dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .tile_rows      (tile_rows),
    .num_tiles      (num_tiles),
    .s_valid        (s_valid),
    .s_value        (s_value),
    .s_ready        (s_ready),
    .fifo_half_full (fifo_half_full),
    .wrreq          (wrreq),
    .wr_value       (wr_value),
    .wr_valid       (wr_valid),
    .wr_new_tile_k  (wr_new_tile_k),
    .wr_last_elm    (wr_last_elm),
    .busy           (busy),
    .done           (done)
  );

  typedef struct {
    logic [ROWS_W-1:0]   rows;
    logic [NTILES_W-1:0] ntiles;
    int                  eff_rows;
    int                  eff_tiles;
    bit                  stall;
    bit                  randv;
    bit                  restart;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [WORD_W-1:0] act,
                         input logic [WORD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] word(input int i);
    logic [31:0] x;
    x = {16'hC0DE, 16'(i + 1)};
    return {(WORD_W/32){x}};
  endfunction

  // abort_at >= 0: assert reset once that many writes have been observed.
  task automatic run_case(input vec_t v, input int abort_at);
    int total_w, total_a, wcnt, acnt, dones, done_cyc, last_wr_cyc;
    bit prev_hf;
    total_w = v.eff_tiles * SZI;
    total_a = v.eff_tiles * v.eff_rows;
    wcnt = 0; acnt = 0; dones = 0; done_cyc = -1; last_wr_cyc = -1; prev_hf = 1'b0;

    @(negedge clk);
    start = 1'b1; tile_rows = v.rows; num_tiles = v.ntiles;
    s_valid = 1'b0; fifo_half_full = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_i("busy_after_start", int'(busy), 1);

    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (wrreq) begin
        int t, r;
        logic [WORD_W-1:0] ev;
        t  = wcnt / SZI;
        r  = wcnt % SZI;
        ev = (r < v.eff_rows) ? word(t * v.eff_rows + r) : '0;
        check_w("wr_value", wr_value, ev);
        check_i("wr_new_tile_k", int'(wr_new_tile_k), int'(r == 0));
        check_i("wr_last_elm", int'(wr_last_elm), int'(wcnt == total_w - 1));
        check_i("wr_valid", int'(wr_valid), 1);
        check_i("write_after_half_full", int'(prev_hf), 0);
        wcnt++;
        last_wr_cyc = cyc;
      end else begin
        check_i("idle_tags", int'({wr_valid, wr_new_tile_k, wr_last_elm, |wr_value}), 0);
      end

      if (abort_at >= 0 && wcnt == abort_at) begin
        resetn = 1'b0; s_valid = 1'b0; fifo_half_full = 1'b0;
        @(negedge clk);
        check_i("rst_wrreq", int'(wrreq), 0);
        check_i("rst_tags", int'({wr_valid, wr_new_tile_k, wr_last_elm}), 0);
        check_w("rst_wr_value", wr_value, '0);
        check_i("rst_busy_done", int'({busy, done}), 0);
        check_i("rst_s_ready", int'(s_ready), 0);
        resetn = 1'b1;
        return;
      end

      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        check_i("busy_with_done", int'(busy), 1);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 3) break;

      fifo_half_full = v.stall ? ((cyc / 3) % 2 == 1) : 1'b0;
      s_valid        = v.randv ? 1'($urandom_range(0, 1)) : 1'b1;
      s_value        = word(acnt);
      start          = v.restart && (cyc == 4);
      tile_rows      = start ? ROWS_W'(3) : v.rows;
      num_tiles      = start ? NTILES_W'(7) : v.ntiles;
      #1;
      if (s_valid && s_ready) acnt++;
      prev_hf = fifo_half_full;
      @(negedge clk);
    end

    start = 1'b0; s_valid = 1'b0; fifo_half_full = 1'b0;
    check_i("write_count", wcnt, total_w);
    check_i("accept_count", acnt, total_a);
    check_i("done_pulses", dones, 1);
    check_i("done_latency", done_cyc - last_wr_cyc, 1);
    check_i("busy_after_done", int'(busy), 0);
    check_i("s_ready_idle", int'(s_ready), 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{5'd16, 13'd2, 16, 2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd10, 13'd3, 10, 3, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd10, 13'd3, 10, 3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{5'd16, 13'd1, 16, 1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{5'd4,  13'd2, 4,  2, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{5'd0,  13'd0, 16, 1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{5'd20, 13'd1, 16, 1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{5'd1,  13'd2, 1,  2, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{5'd6,  13'd2, 6,  2, 1'b0, 1'b0, 1'b1};

    resetn = 1'b0; start = 1'b0; tile_rows = '0; num_tiles = '0;
    s_valid = 1'b0; s_value = '0; fifo_half_full = 1'b0;
    repeat (3) @(negedge clk);
    check_i("reset_wrreq", int'(wrreq), 0);
    check_i("reset_tags", int'({wr_valid, wr_new_tile_k, wr_last_elm}), 0);
    check_w("reset_wr_value", wr_value, '0);
    check_i("reset_busy", int'(busy), 0);
    check_i("reset_done", int'(done), 0);
    check_i("reset_s_ready", int'(s_ready), 0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) run_case(vecs[i], -1);

    run_case('{5'd16, 13'd2, 16, 2, 1'b0, 1'b0, 1'b0}, 21);
    run_case('{5'd4,  13'd1, 4,  1, 1'b0, 1'b0, 1'b0}, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
